// File: rtl/syscall_print_ctrl_if.sv
// Data-memory style request bus: one requester drives read/write/addr/wdata,
// the responder returns combinational rdata.
interface syscall_print_ctrl_if;
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output read, write, addr, wdata,
        input  rdata
    );

    modport slave (
        input  read, write, addr, wdata,
        output rdata
    );
endinterface

// File: rtl/syscall_print_ctrl.sv
// SYSCALL sequencer: stalls ID, drains MEM/WB, prints ints/chars/strings,
// and shares the single data-memory port with the MEM stage.
module syscall_print_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned MAX_LEN      = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 syscall_valid,
    input  logic [31:0]          v0_val,
    input  logic [31:0]          a0_val,
    syscall_print_ctrl_if.slave  p,
    syscall_print_ctrl_if.master dm,
    output logic                 stall,
    output logic                 char_valid,
    output logic [7:0]           char_data,
    output logic                 int_valid,
    output logic [31:0]          int_data,
    output logic                 halt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRAIN = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_STR   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;

    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int unsigned CW = $clog2(MAX_LEN + 1);

    logic [2:0]    state_q, state_d;
    logic [31:0]   code_q, code_d;
    logic [31:0]   ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          char_valid_q, char_valid_d;
    logic [7:0]    char_data_q, char_data_d;
    logic          int_valid_q, int_valid_d;
    logic [31:0]   int_data_q, int_data_d;
    logic          halt_q, halt_d;

    logic          own;
    logic [7:0]    str_byte;

    assign own      = (state_q == S_STR);
    assign str_byte = dm.rdata[{ptr_q[1:0], 3'b000} +: 8];

    // MEM stage sees the port unless the string engine holds it
    assign dm.read  = own ? 1'b1 : p.read;
    assign dm.write = own ? 1'b0 : p.write;
    assign dm.addr  = own ? {ptr_q[31:2], 2'b00} : p.addr;
    assign dm.wdata = p.wdata;
    assign p.rdata  = dm.rdata;

    assign stall      = (state_q == S_IDLE) ? syscall_valid
                                            : (state_q != S_DONE);
    assign char_valid = char_valid_q;
    assign char_data  = char_data_q;
    assign int_valid  = int_valid_q;
    assign int_data   = int_data_q;
    assign halt       = halt_q;

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        drain_d      = drain_q;
        char_valid_d = 1'b0;
        char_data_d  = char_data_q;
        int_valid_d  = 1'b0;
        int_data_d   = int_data_q;
        halt_d       = halt_q;
        unique case (state_q)
            S_IDLE: begin
                if (syscall_valid) begin
                    code_d  = v0_val;
                    ptr_d   = a0_val;
                    cnt_d   = '0;
                    drain_d = DW'(DRAIN_CYCLES - 1);
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) state_d = S_EXEC;
                else               drain_d = drain_q - 1'b1;
            end
            S_EXEC: begin
                state_d = S_DONE;
                if (code_q == 32'd1) begin
                    int_valid_d = 1'b1;
                    int_data_d  = ptr_q;
                end else if (code_q == 32'd11) begin
                    char_valid_d = 1'b1;
                    char_data_d  = ptr_q[7:0];
                end else if (code_q == 32'd4) begin
                    state_d = S_STR;
                end else if (code_q == 32'd10) begin
                    halt_d  = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_STR: begin
                if (str_byte != 8'd0 && cnt_q < CW'(MAX_LEN)) begin
                    char_valid_d = 1'b1;
                    char_data_d  = str_byte;
                    ptr_d        = ptr_q + 32'd1;
                    cnt_d        = cnt_q + 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_HALT:  halt_d  = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            code_q       <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            drain_q      <= '0;
            char_valid_q <= 1'b0;
            char_data_q  <= '0;
            int_valid_q  <= 1'b0;
            int_data_q   <= '0;
            halt_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            drain_q      <= drain_d;
            char_valid_q <= char_valid_d;
            char_data_q  <= char_data_d;
            int_valid_q  <= int_valid_d;
            int_data_q   <= int_data_d;
            halt_q       <= halt_d;
        end
    end

endmodule
